// File: rtl/axi_lite_pkg.sv
// Shared types and defaults for the AXI4-Lite master.
//   resp_e      : AXI response codes (BRESP/RRESP)
//   mst_state_e : master FSM states
//   AXIL_ADDR_W / AXIL_DATA_W : default address/data widths
package axi_lite_pkg;

  localparam int AXIL_ADDR_W = 4;
  localparam int AXIL_DATA_W = 32;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    DONE
  } mst_state_e;

endpackage

// File: rtl/axi_lite_timeout_ctr.sv
// Response-wait watchdog for the AXI-Lite master.
// Ports:
//   ACLK, ARESETn : clock, asynchronous active-low reset
//   clear         : hold the count at zero
//   enable        : count one per cycle while not cleared
//   expire        : count has reached TIMEOUT-1 (never when TIMEOUT = 0)
module axi_lite_timeout_ctr #(
  parameter int TIMEOUT = 256
) (
  input  logic ACLK,
  input  logic ARESETn,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  if (TIMEOUT == 0) begin : g_off
    assign expire = 1'b0;
  end else begin : g_on
    assign expire = enable && (count_reg == LAST);
  end

endmodule

// File: rtl/axi_lite_master.sv
// AXI4-Lite master: converts a single-entry command interface into one
// AXI-Lite write or read at a time and reports the result on rsp_*.
// Ports:
//   ACLK, ARESETn          : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    : command handshake (cmd_write, cmd_addr, cmd_wdata)
//   rsp_valid              : one-cycle completion pulse with rsp_write,
//                            rsp_rdata, rsp_resp, rsp_timeout
//   AW/W/B/AR/R channels   : AXI4-Lite master side
module axi_lite_master import axi_lite_pkg::*; #(
  parameter int ADDR_W  = AXIL_ADDR_W,
  parameter int DATA_W  = AXIL_DATA_W,
  parameter int TIMEOUT = 256
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] AWADDR,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY,
  output logic [ADDR_W-1:0] ARADDR,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic              RVALID,
  output logic              RREADY,
  input  logic [1:0]        RRESP
);

  mst_state_e        state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              awvalid_reg, awvalid_next;
  logic              wvalid_reg, wvalid_next;
  logic              aw_done_reg, aw_done_next;
  logic              w_done_reg, w_done_next;
  logic              bready_reg, bready_next;
  logic              arvalid_reg, arvalid_next;
  logic              rready_reg, rready_next;
  logic              rsp_valid_reg, rsp_valid_next;
  logic              rsp_write_reg, rsp_write_next;
  logic [DATA_W-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic [1:0]        rsp_resp_reg, rsp_resp_next;
  logic              rsp_timeout_reg, rsp_timeout_next;
  // Keeps cmd_ready low until the first clock edge after reset release.
  logic              ready_en_reg;
  logic              tmo_clear, tmo_expire;

  // The counter sits at zero outside the two response-wait states, so it
  // reads zero on the first cycle after entering either of them.
  assign tmo_clear = !((state_reg == WR_RESP) || (state_reg == RD_DATA));

  axi_lite_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .clear   (tmo_clear),
    .enable  (!tmo_clear),
    .expire  (tmo_expire)
  );

  assign cmd_ready = ready_en_reg && (state_reg == IDLE);

  always_comb begin
    state_next       = state_reg;
    addr_next        = addr_reg;
    wdata_next       = wdata_reg;
    awvalid_next     = awvalid_reg;
    wvalid_next      = wvalid_reg;
    aw_done_next     = aw_done_reg;
    w_done_next      = w_done_reg;
    bready_next      = bready_reg;
    arvalid_next     = arvalid_reg;
    rready_next      = rready_reg;
    rsp_valid_next   = 1'b0;
    rsp_write_next   = rsp_write_reg;
    rsp_rdata_next   = rsp_rdata_reg;
    rsp_resp_next    = rsp_resp_reg;
    rsp_timeout_next = rsp_timeout_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_ready && cmd_valid) begin
          addr_next  = cmd_addr;
          wdata_next = cmd_wdata;
          if (cmd_write) begin
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
            aw_done_next = 1'b0;
            w_done_next  = 1'b0;
            state_next   = WR_REQ;
          end else begin
            arvalid_next = 1'b1;
            state_next   = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        // AW and W finish independently; each VALID drops after its own
        // handshake and B is only requested once both have happened.
        if (awvalid_reg && AWREADY) begin
          awvalid_next = 1'b0;
          aw_done_next = 1'b1;
        end
        if (wvalid_reg && WREADY) begin
          wvalid_next = 1'b0;
          w_done_next = 1'b1;
        end
        if (aw_done_next && w_done_next) begin
          bready_next = 1'b1;
          state_next  = WR_RESP;
        end
      end
      WR_RESP: begin
        // A response on the expiry cycle wins over the timeout.
        if (BVALID || tmo_expire) begin
          bready_next      = 1'b0;
          rsp_valid_next   = 1'b1;
          rsp_write_next   = 1'b1;
          rsp_rdata_next   = '0;
          rsp_resp_next    = BVALID ? BRESP : SLVERR;
          rsp_timeout_next = !BVALID;
          state_next       = DONE;
        end
      end
      RD_REQ: begin
        if (ARREADY) begin
          arvalid_next = 1'b0;
          rready_next  = 1'b1;
          state_next   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (RVALID || tmo_expire) begin
          rready_next      = 1'b0;
          rsp_valid_next   = 1'b1;
          rsp_write_next   = 1'b0;
          rsp_rdata_next   = RVALID ? RDATA : '0;
          rsp_resp_next    = RVALID ? RRESP : SLVERR;
          rsp_timeout_next = !RVALID;
          state_next       = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_reg       <= IDLE;
      ready_en_reg    <= 1'b0;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      awvalid_reg     <= 1'b0;
      wvalid_reg      <= 1'b0;
      aw_done_reg     <= 1'b0;
      w_done_reg      <= 1'b0;
      bready_reg      <= 1'b0;
      arvalid_reg     <= 1'b0;
      rready_reg      <= 1'b0;
      rsp_valid_reg   <= 1'b0;
      rsp_write_reg   <= 1'b0;
      rsp_rdata_reg   <= '0;
      rsp_resp_reg    <= '0;
      rsp_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      ready_en_reg    <= 1'b1;
      addr_reg        <= addr_next;
      wdata_reg       <= wdata_next;
      awvalid_reg     <= awvalid_next;
      wvalid_reg      <= wvalid_next;
      aw_done_reg     <= aw_done_next;
      w_done_reg      <= w_done_next;
      bready_reg      <= bready_next;
      arvalid_reg     <= arvalid_next;
      rready_reg      <= rready_next;
      rsp_valid_reg   <= rsp_valid_next;
      rsp_write_reg   <= rsp_write_next;
      rsp_rdata_reg   <= rsp_rdata_next;
      rsp_resp_reg    <= rsp_resp_next;
      rsp_timeout_reg <= rsp_timeout_next;
    end
  end

  assign AWADDR      = addr_reg;
  assign ARADDR      = addr_reg;
  assign WDATA       = wdata_reg;
  assign AWVALID     = awvalid_reg;
  assign WVALID      = wvalid_reg;
  assign BREADY      = bready_reg;
  assign ARVALID     = arvalid_reg;
  assign RREADY      = rready_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_write   = rsp_write_reg;
  assign rsp_rdata   = rsp_rdata_reg;
  assign rsp_resp    = rsp_resp_reg;
  assign rsp_timeout = rsp_timeout_reg;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed testbench for axi_lite_master (TIMEOUT = 8). The slave side is
// driven cycle by cycle from each test task; outputs are sampled 1 time
// unit after the rising edge.
module tb_axi_lite_master;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [3:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid, rsp_write, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [3:0]  AWADDR, ARADDR;
  logic        AWVALID, WVALID, BREADY, ARVALID, RREADY;
  logic        AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0, ARREADY = 1'b0, RVALID = 1'b0;
  logic [31:0] WDATA;
  logic [31:0] RDATA = '0;
  logic [1:0]  BRESP = '0, RRESP = '0;
  logic [31:0] slv_mem [4];

  int n_vec = 0;
  int n_err = 0;

  always #5 ACLK = ~ACLK;

  axi_lite_master #(.ADDR_W(4), .DATA_W(32), .TIMEOUT(8)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY), .RRESP(RRESP)
  );

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    tick(); tick();
    n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
    n_vec++; if ({AWVALID, WVALID, BREADY, ARVALID, RREADY} !== 5'b0) begin n_err++; $display("FAIL rst_axi_ctrl: got %b want 00000", {AWVALID, WVALID, BREADY, ARVALID, RREADY}); end
    n_vec++; if ({rsp_valid, rsp_write, rsp_timeout, rsp_resp, rsp_rdata, AWADDR, ARADDR, WDATA} !== '0) begin n_err++; $display("FAIL rst_data: rsp_valid=%b rsp_rdata=%h AWADDR=%h WDATA=%h want all 0", rsp_valid, rsp_rdata, AWADDR, WDATA); end
    ARESETn = 1'b1;
    #1;
    n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL rst_release_ready: got %b want 0 before first edge", cmd_ready); end
    tick();
    n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_first_edge_ready: got %b want 1", cmd_ready); end
    $display("reset: released, cmd_ready=%b", cmd_ready);
  endtask

  task automatic test_write_zero_wait();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h4; cmd_wdata = 32'hDEADBEEF;
    AWREADY = 1'b1; WREADY = 1'b1;
    tick();  // accept
    cmd_valid = 1'b0;
    n_vec++; if ({AWVALID, WVALID} !== 2'b11) begin n_err++; $display("FAIL wr_valids: got %b want 11", {AWVALID, WVALID}); end
    n_vec++; if (AWADDR !== 4'h4) begin n_err++; $display("FAIL wr_awaddr: got %h want 4", AWADDR); end
    n_vec++; if (WDATA !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_wdata: got %h want deadbeef", WDATA); end
    n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL wr_busy_ready: got %b want 0", cmd_ready); end
    slv_mem[AWADDR[3:2]] = WDATA;
    tick();  // AW/W handshake
    AWREADY = 1'b0; WREADY = 1'b0;
    n_vec++; if ({AWVALID, WVALID, BREADY} !== 3'b001) begin n_err++; $display("FAIL wr_after_hs: AWVALID,WVALID,BREADY got %b want 001", {AWVALID, WVALID, BREADY}); end
    BVALID = 1'b1; BRESP = 2'b00;
    tick();  // B handshake
    BVALID = 1'b0;
    n_vec++; if ({rsp_valid, rsp_write, rsp_timeout, BREADY} !== 4'b1100) begin n_err++; $display("FAIL wr_rsp: valid,write,timeout,BREADY got %b want 1100", {rsp_valid, rsp_write, rsp_timeout, BREADY}); end
    n_vec++; if (rsp_resp !== 2'b00) begin n_err++; $display("FAIL wr_rsp_resp: got %b want 00", rsp_resp); end
    n_vec++; if (rsp_rdata !== 32'h0) begin n_err++; $display("FAIL wr_rsp_rdata: got %h want 0", rsp_rdata); end
    $display("write addr=4 data=deadbeef resp=%b", rsp_resp);
    tick();
    n_vec++; if ({rsp_valid, cmd_ready} !== 2'b01) begin n_err++; $display("FAIL wr_done_exit: rsp_valid,cmd_ready got %b want 01", {rsp_valid, cmd_ready}); end
  endtask

  task automatic test_read();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h4; cmd_wdata = 32'h0;
    ARREADY = 1'b1;
    tick();
    cmd_valid = 1'b0;
    n_vec++; if ({ARVALID, AWVALID, WVALID} !== 3'b100) begin n_err++; $display("FAIL rd_valids: ARVALID,AWVALID,WVALID got %b want 100", {ARVALID, AWVALID, WVALID}); end
    n_vec++; if (ARADDR !== 4'h4) begin n_err++; $display("FAIL rd_araddr: got %h want 4", ARADDR); end
    tick();  // AR handshake
    ARREADY = 1'b0;
    n_vec++; if ({ARVALID, RREADY} !== 2'b01) begin n_err++; $display("FAIL rd_after_ar: ARVALID,RREADY got %b want 01", {ARVALID, RREADY}); end
    RVALID = 1'b1; RDATA = slv_mem[ARADDR[3:2]]; RRESP = 2'b00;
    tick();
    RVALID = 1'b0; RDATA = 32'h0;
    n_vec++; if ({rsp_valid, rsp_write, rsp_timeout, RREADY} !== 4'b1000) begin n_err++; $display("FAIL rd_rsp: valid,write,timeout,RREADY got %b want 1000", {rsp_valid, rsp_write, rsp_timeout, RREADY}); end
    n_vec++; if (rsp_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_rdata: got %h want deadbeef", rsp_rdata); end
    n_vec++; if (rsp_resp !== 2'b00) begin n_err++; $display("FAIL rd_resp: got %b want 00", rsp_resp); end
    $display("read addr=4 data=%h resp=%b", rsp_rdata, rsp_resp);
    tick();
    n_vec++; if ({rsp_valid, cmd_ready} !== 2'b01) begin n_err++; $display("FAIL rd_done_exit: rsp_valid,cmd_ready got %b want 01", {rsp_valid, cmd_ready}); end
  endtask

  task automatic test_skewed_write();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h8; cmd_wdata = 32'h12345678;
    AWREADY = 1'b0; WREADY = 1'b1;
    tick();
    cmd_valid = 1'b0;
    n_vec++; if ({AWVALID, WVALID} !== 2'b11) begin n_err++; $display("FAIL skew_valids: got %b want 11", {AWVALID, WVALID}); end
    tick();  // W handshake only
    WREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_vec++; if ({AWVALID, WVALID, BREADY} !== 3'b100) begin n_err++; $display("FAIL skew_hold%0d: AWVALID,WVALID,BREADY got %b want 100", i, {AWVALID, WVALID, BREADY}); end
      n_vec++; if (AWADDR !== 4'h8) begin n_err++; $display("FAIL skew_awaddr%0d: got %h want 8", i, AWADDR); end
      if (i == 2) AWREADY = 1'b1;
      else tick();
    end
    tick();  // AW handshake, three cycles after W
    AWREADY = 1'b0;
    n_vec++; if ({AWVALID, BREADY} !== 2'b01) begin n_err++; $display("FAIL skew_bready: AWVALID,BREADY got %b want 01", {AWVALID, BREADY}); end
    BVALID = 1'b1; BRESP = 2'b00;
    tick();
    BVALID = 1'b0;
    n_vec++; if ({rsp_valid, rsp_write} !== 2'b11) begin n_err++; $display("FAIL skew_rsp: valid,write got %b want 11", {rsp_valid, rsp_write}); end
    $display("write addr=8 data=12345678 (skewed) resp=%b", rsp_resp);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL skew_single_rsp%0d: rsp_valid got %b want 0", i, rsp_valid); end
    end
  endtask

  task automatic test_read_timeout();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'hC;
    ARREADY = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();  // AR handshake: RD_DATA entered on this edge
    ARREADY = 1'b0;
    for (int i = 1; i < 8; i++) begin
      n_vec++; if ({RREADY, rsp_valid} !== 2'b10) begin n_err++; $display("FAIL tmo_wait%0d: RREADY,rsp_valid got %b want 10", i, {RREADY, rsp_valid}); end
      tick();
    end
    tick();  // eighth edge after entry
    n_vec++; if ({RREADY, rsp_valid, rsp_timeout, rsp_write} !== 4'b0110) begin n_err++; $display("FAIL tmo_rsp: RREADY,valid,timeout,write got %b want 0110", {RREADY, rsp_valid, rsp_timeout, rsp_write}); end
    n_vec++; if (rsp_resp !== 2'b10) begin n_err++; $display("FAIL tmo_resp: got %b want 10", rsp_resp); end
    n_vec++; if (rsp_rdata !== 32'h0) begin n_err++; $display("FAIL tmo_rdata: got %h want 0", rsp_rdata); end
    $display("read addr=c timeout resp=%b timeout=%b", rsp_resp, rsp_timeout);
    tick();
  endtask

  // Write whose BVALID arrives after 'delay' cycles in WR_RESP.
  task automatic test_bresp_delay(input int delay, input logic [1:0] resp);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h0; cmd_wdata = 32'hA5A5A5A5;
    AWREADY = 1'b1; WREADY = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();  // handshake: WR_RESP entered on this edge
    AWREADY = 1'b0; WREADY = 1'b0;
    for (int i = 1; i < delay; i++) begin
      n_vec++; if ({BREADY, rsp_valid} !== 2'b10) begin n_err++; $display("FAIL bdly%0d_wait%0d: BREADY,rsp_valid got %b want 10", delay, i, {BREADY, rsp_valid}); end
      tick();
    end
    BVALID = 1'b1; BRESP = resp;
    tick();
    BVALID = 1'b0; BRESP = 2'b00;
    n_vec++; if ({rsp_valid, rsp_timeout, BREADY} !== 3'b100) begin n_err++; $display("FAIL bdly%0d_rsp: valid,timeout,BREADY got %b want 100", delay, {rsp_valid, rsp_timeout, BREADY}); end
    n_vec++; if (rsp_resp !== resp) begin n_err++; $display("FAIL bdly%0d_resp: got %b want %b", delay, rsp_resp, resp); end
    $display("write addr=0 data=a5a5a5a5 bdelay=%0d resp=%b timeout=%b", delay, rsp_resp, rsp_timeout);
    tick();
  endtask

  task automatic test_reset_mid_write();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h8; cmd_wdata = 32'hCAFEF00D;
    AWREADY = 1'b0; WREADY = 1'b0;
    tick();
    cmd_valid = 1'b0;
    n_vec++; if (AWVALID !== 1'b1) begin n_err++; $display("FAIL mid_pre_awvalid: got %b want 1", AWVALID); end
    #2 ARESETn = 1'b0;
    #1;
    n_vec++; if ({AWVALID, WVALID, BREADY, ARVALID, RREADY, cmd_ready, rsp_valid} !== 7'b0) begin n_err++; $display("FAIL mid_async_drop: got %b want 0000000", {AWVALID, WVALID, BREADY, ARVALID, RREADY, cmd_ready, rsp_valid}); end
    n_vec++; if ({AWADDR, WDATA} !== '0) begin n_err++; $display("FAIL mid_async_data: AWADDR=%h WDATA=%h want 0", AWADDR, WDATA); end
    tick();
    ARESETn = 1'b1;
    #1;
    n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL mid_release_ready: got %b want 0", cmd_ready); end
    tick();
    n_vec++; if ({cmd_ready, rsp_valid, AWVALID} !== 3'b100) begin n_err++; $display("FAIL mid_after_edge: cmd_ready,rsp_valid,AWVALID got %b want 100", {cmd_ready, rsp_valid, AWVALID}); end
    $display("reset during write: transaction abandoned");
    test_read();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) slv_mem[i] = 32'h0;
    test_reset();
    test_write_zero_wait();
    test_read();
    test_skewed_write();
    test_read_timeout();
    test_bresp_delay(5, 2'b11);
    test_bresp_delay(8, 2'b01);  // response on the expiry cycle
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
